// File: rtl/gam_edge_table_pkg.sv
// Shared defaults, edge record and FSM state type for the GAM edge table.
package gam_edge_table_pkg;
    localparam int unsigned CLASS_COUNT_DEF = 4;
    localparam int unsigned NODE_COUNT_DEF  = 16;
    localparam int unsigned AGE_W_DEF       = 6;
    localparam int unsigned AGE_MAX_DEF     = 20;
    // Storage width of the age field; instances use only the low AGE_W bits.
    localparam int unsigned AGE_W_MAX       = 8;

    typedef struct packed {
        logic                 present;
        logic [AGE_W_MAX-1:0] age;
    } edge_t;

    typedef enum logic [1:0] {IDLE, AGE_SWEEP, PRUNE, DONE} gam_state_t;
endpackage

// File: rtl/gam_edge_table_row_prune.sv
// Combinational row pruner: drops edges whose age reached the threshold and flags an empty row.
module gam_edge_row_prune
    import gam_edge_table_pkg::*;
#(
    parameter int unsigned NODE_COUNT = NODE_COUNT_DEF,
    parameter int unsigned AGE_MAX    = AGE_MAX_DEF
) (
    input  edge_t row_in  [NODE_COUNT],
    output edge_t row_out [NODE_COUNT],
    output logic  row_empty
);
    always_comb begin
        row_empty = 1'b1;
        for (int unsigned c = 0; c < NODE_COUNT; c++) begin
            row_out[c] = row_in[c];
            if (row_in[c].age >= AGE_W_MAX'(AGE_MAX))
                row_out[c].present = 1'b0;
            if (row_out[c].present)
                row_empty = 1'b0;
        end
    end
endmodule

// File: rtl/gam_edge_table.sv
// Per-class symmetric edge table with age sweep on connect and threshold pruning on request.
module gam_edge_table
    import gam_edge_table_pkg::*;
#(
    parameter int unsigned CLASS_COUNT = CLASS_COUNT_DEF,
    parameter int unsigned NODE_COUNT  = NODE_COUNT_DEF,
    parameter int unsigned AGE_W       = AGE_W_DEF,
    parameter int unsigned AGE_MAX     = AGE_MAX_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [$clog2(CLASS_COUNT)-1:0] cmd_class,
    input  logic [$clog2(NODE_COUNT)-1:0]  cmd_node1,
    input  logic [$clog2(NODE_COUNT)-1:0]  cmd_node2,
    output logic                           cmd_err,
    input  logic                           prune_start,
    output logic                           busy,
    output logic                           prune_done,
    input  logic [$clog2(CLASS_COUNT)-1:0] rd_class,
    input  logic [$clog2(NODE_COUNT)-1:0]  rd_node1,
    input  logic [$clog2(NODE_COUNT)-1:0]  rd_node2,
    output logic                           rd_present,
    output logic [AGE_W-1:0]               rd_age,
    output logic                           rd_invalid
);
    localparam int unsigned CW = $clog2(CLASS_COUNT);
    localparam int unsigned NW = $clog2(NODE_COUNT);
    localparam int unsigned SW = NW + 1;
    localparam logic [AGE_W_MAX-1:0] AGE_SAT = AGE_W_MAX'((1 << AGE_W) - 1);

    gam_state_t    state;
    edge_t         edges   [CLASS_COUNT][NODE_COUNT][NODE_COUNT];
    logic          invalid [CLASS_COUNT][NODE_COUNT];
    logic [CW-1:0] cur_class;
    logic [NW-1:0] cur_n1;
    logic [NW-1:0] cur_n2;
    logic [SW-1:0] sweep_idx;
    logic [NW-1:0] sweep_n;
    logic [CW-1:0] prune_class;
    logic [NW-1:0] prune_row;
    edge_t         row_in  [NODE_COUNT];
    edge_t         row_out [NODE_COUNT];
    logic          row_empty;
    logic          cmd_ok;
    logic          rd_row_ok;
    logic          rd_col_ok;

    assign cmd_ready = (state == IDLE) && !prune_start;
    assign busy      = (state != IDLE);
    assign sweep_n   = sweep_idx[NW-1:0];

    assign cmd_ok = (cmd_class != '0) && (32'(cmd_class) < CLASS_COUNT) &&
                    (cmd_node1 != '0) && (32'(cmd_node1) < NODE_COUNT) &&
                    (cmd_node2 != '0) && (32'(cmd_node2) < NODE_COUNT) &&
                    (cmd_node1 != cmd_node2);
    assign rd_row_ok = (rd_class != '0) && (32'(rd_class) < CLASS_COUNT) &&
                       (rd_node1 != '0) && (32'(rd_node1) < NODE_COUNT);
    assign rd_col_ok = (rd_node2 != '0) && (32'(rd_node2) < NODE_COUNT);

    always_comb begin
        for (int unsigned c = 0; c < NODE_COUNT; c++)
            row_in[c] = edges[prune_class][prune_row][c];
    end

    gam_edge_row_prune #(
        .NODE_COUNT (NODE_COUNT),
        .AGE_MAX    (AGE_MAX)
    ) u_row_prune (
        .row_in    (row_in),
        .row_out   (row_out),
        .row_empty (row_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_err     <= 1'b0;
            prune_done  <= 1'b0;
            cur_class   <= '0;
            cur_n1      <= '0;
            cur_n2      <= '0;
            sweep_idx   <= '0;
            prune_class <= '0;
            prune_row   <= '0;
            rd_present  <= 1'b0;
            rd_age      <= '0;
            rd_invalid  <= 1'b0;
            for (int unsigned c = 0; c < CLASS_COUNT; c++) begin
                for (int unsigned a = 0; a < NODE_COUNT; a++) begin
                    invalid[c][a] <= 1'b0;
                    for (int unsigned b = 0; b < NODE_COUNT; b++)
                        edges[c][a][b] <= '0;
                end
            end
        end else begin
            cmd_err    <= 1'b0;
            prune_done <= 1'b0;
            rd_present <= 1'b0;
            rd_age     <= '0;
            rd_invalid <= 1'b0;
            if (rd_row_ok) begin
                rd_invalid <= invalid[rd_class][rd_node1];
                if (rd_col_ok) begin
                    rd_present <= edges[rd_class][rd_node1][rd_node2].present;
                    rd_age     <= edges[rd_class][rd_node1][rd_node2].age[AGE_W-1:0];
                end
            end

            unique case (state)
                IDLE: begin
                    if (prune_start) begin
                        state       <= PRUNE;
                        prune_class <= CW'(1);
                        prune_row   <= NW'(1);
                    end else if (cmd_valid) begin
                        if (cmd_ok) begin
                            edges[cmd_class][cmd_node1][cmd_node2] <= '{present: 1'b1, age: '0};
                            edges[cmd_class][cmd_node2][cmd_node1] <= '{present: 1'b1, age: '0};
                            invalid[cmd_class][cmd_node1] <= 1'b0;
                            invalid[cmd_class][cmd_node2] <= 1'b0;
                            cur_class <= cmd_class;
                            cur_n1    <= cmd_node1;
                            cur_n2    <= cmd_node2;
                            sweep_idx <= SW'(1);
                            state     <= AGE_SWEEP;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                AGE_SWEEP: begin
                    // Index NODE_COUNT is a terminal step so the sweep spans NODE_COUNT cycles.
                    if (sweep_idx == SW'(NODE_COUNT)) begin
                        state <= IDLE;
                    end else begin
                        if (sweep_n != cur_n1 && sweep_n != cur_n2 &&
                            edges[cur_class][cur_n1][sweep_n].present &&
                            edges[cur_class][cur_n1][sweep_n].age != AGE_SAT) begin
                            edges[cur_class][cur_n1][sweep_n].age <= edges[cur_class][cur_n1][sweep_n].age + 1'b1;
                            edges[cur_class][sweep_n][cur_n1].age <= edges[cur_class][cur_n1][sweep_n].age + 1'b1;
                        end
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                PRUNE: begin
                    // Mirror each cleared entry into its column to keep the table symmetric.
                    for (int unsigned c = 0; c < NODE_COUNT; c++) begin
                        edges[prune_class][prune_row][c] <= row_out[c];
                        if (row_in[c].present && !row_out[c].present)
                            edges[prune_class][c][prune_row].present <= 1'b0;
                    end
                    invalid[prune_class][prune_row] <= row_empty;
                    if (prune_row == NW'(NODE_COUNT - 1)) begin
                        prune_row <= NW'(1);
                        if (prune_class == CW'(CLASS_COUNT - 1)) begin
                            state      <= DONE;
                            prune_done <= 1'b1;
                        end else begin
                            prune_class <= prune_class + 1'b1;
                        end
                    end else begin
                        prune_row <= prune_row + 1'b1;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gam_edge_table.sv
// Directed bench for gam_edge_table with a whole-table behavioural model and per-cycle read checks.
module tb_gam_edge_table;
    localparam int NC = 8;
    localparam int SAT = 15;
    localparam int THR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_err;
    logic [1:0] cmd_class, rd_class;
    logic [2:0] cmd_node1, cmd_node2, rd_node1, rd_node2;
    logic       prune_start, busy, prune_done;
    logic       rd_present, rd_invalid;
    logic [3:0] rd_age;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_p [4][NC][NC];
    int m_a [4][NC][NC];
    bit m_i [4][NC];
    int cap_c, cap_a, cap_b;

    gam_edge_table #(
        .CLASS_COUNT (3),
        .NODE_COUNT  (8),
        .AGE_W       (4),
        .AGE_MAX     (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_class   (cmd_class),
        .cmd_node1   (cmd_node1),
        .cmd_node2   (cmd_node2),
        .cmd_err     (cmd_err),
        .prune_start (prune_start),
        .busy        (busy),
        .prune_done  (prune_done),
        .rd_class    (rd_class),
        .rd_node1    (rd_node1),
        .rd_node2    (rd_node2),
        .rd_present  (rd_present),
        .rd_age      (rd_age),
        .rd_invalid  (rd_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < NC; a++) begin
                m_i[c][a] = 1'b0;
                for (int b = 0; b < NC; b++) begin
                    m_p[c][a][b] = 1'b0;
                    m_a[c][a][b] = 0;
                end
            end
    endfunction

    // Whole connect at once: age existing neighbours of n1, then (re)create the new edge.
    function automatic void model_connect(int c, int n1, int n2);
        for (int i = 1; i < NC; i++)
            if (i != n1 && i != n2 && m_p[c][n1][i]) begin
                m_a[c][n1][i] = (m_a[c][n1][i] >= SAT) ? SAT : m_a[c][n1][i] + 1;
                m_a[c][i][n1] = m_a[c][n1][i];
            end
        m_p[c][n1][n2] = 1'b1; m_p[c][n2][n1] = 1'b1;
        m_a[c][n1][n2] = 0;    m_a[c][n2][n1] = 0;
        m_i[c][n1] = 1'b0;     m_i[c][n2] = 1'b0;
    endfunction

    function automatic void model_prune();
        for (int c = 1; c < 3; c++) begin
            for (int a = 1; a < NC; a++)
                for (int b = 1; b < NC; b++)
                    if (m_p[c][a][b] && m_a[c][a][b] >= THR) m_p[c][a][b] = 1'b0;
            for (int a = 1; a < NC; a++) begin
                m_i[c][a] = 1'b1;
                for (int b = 1; b < NC; b++)
                    if (m_p[c][a][b]) m_i[c][a] = 1'b0;
            end
        end
    endfunction

    always @(posedge clk) begin
        cap_c <= int'(rd_class);
        cap_a <= int'(rd_node1);
        cap_b <= int'(rd_node2);
    end

    // While idle the table is static, so every read result must match the model.
    always @(negedge clk) begin
        if (rst_n && !busy) begin
            bit ok_row, ok_col;
            ok_row = cap_c >= 1 && cap_c <= 2 && cap_a >= 1;
            ok_col = ok_row && cap_b >= 1;
            chk($sformatf("rd_present[%0d][%0d][%0d]", cap_c, cap_a, cap_b), int'(rd_present),
                ok_col ? int'(m_p[cap_c][cap_a][cap_b]) : 0);
            chk($sformatf("rd_age[%0d][%0d][%0d]", cap_c, cap_a, cap_b), int'(rd_age),
                ok_col ? m_a[cap_c][cap_a][cap_b] : 0);
            chk($sformatf("rd_invalid[%0d][%0d]", cap_c, cap_a), int'(rd_invalid),
                ok_row ? int'(m_i[cap_c][cap_a]) : 0);
        end
    end

    task automatic connect(input int c, input int n1, input int n2, output int low);
        cmd_class = 2'(c); cmd_node1 = 3'(n1); cmd_node2 = 3'(n2); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_connect(c, n1, n2);
        low = 0;
        while (!cmd_ready && low < 100) begin
            @(posedge clk); #1;
            low++;
        end
    endtask

    task automatic bad_cmd(input string nm, input int c, input int n1, input int n2);
        cmd_class = 2'(c); cmd_node1 = 3'(n1); cmd_node2 = 3'(n2); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({nm, " cmd_err"}, int'(cmd_err), 1);
        chk({nm, " busy"}, int'(busy), 0);
        @(posedge clk); #1;
        chk({nm, " cmd_err end"}, int'(cmd_err), 0);
    endtask

    task automatic rd_check(input string nm, input int c, input int a, input int b,
                            input int ep, input int ea, input int ei);
        rd_class = 2'(c); rd_node1 = 3'(a); rd_node2 = 3'(b);
        @(posedge clk); #1;
        chk({nm, " present"}, int'(rd_present), ep);
        chk({nm, " age"}, int'(rd_age), ea);
        chk({nm, " invalid"}, int'(rd_invalid), ei);
    endtask

    task automatic scan_all();
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < NC; a++)
                for (int b = 0; b < NC; b++) begin
                    rd_class = 2'(c); rd_node1 = 3'(a); rd_node2 = 3'(b);
                    @(posedge clk); #1;
                end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cyc;
        rst_n = 1'b0; cmd_valid = 1'b0; prune_start = 1'b0;
        cmd_class = '0; cmd_node1 = '0; cmd_node2 = '0;
        rd_class = '0; rd_node1 = '0; rd_node2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset cmd_ready", int'(cmd_ready), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset cmd_err", int'(cmd_err), 0);
        chk("reset prune_done", int'(prune_done), 0);
        chk("reset rd_present", int'(rd_present), 0);
        chk("reset rd_age", int'(rd_age), 0);
        chk("reset rd_invalid", int'(rd_invalid), 0);

        connect(1, 2, 3, lat);
        chk("connect latency", lat, 8);
        rd_check("first (2,3)", 1, 2, 3, 1, 0, 0);
        rd_check("first (3,2)", 1, 3, 2, 1, 0, 0);

        connect(1, 2, 5, lat);
        chk("second latency", lat, 8);
        rd_check("aged (2,3)", 1, 2, 3, 1, 1, 0);
        rd_check("aged (3,2)", 1, 3, 2, 1, 1, 0);
        rd_check("new (2,5)", 1, 2, 5, 1, 0, 0);
        rd_check("absent (2,4)", 1, 2, 4, 0, 0, 0);

        bad_cmd("same node", 1, 4, 4);
        bad_cmd("class zero", 0, 2, 3);
        bad_cmd("class oor", 3, 2, 3);
        bad_cmd("node zero", 1, 0, 3);
        rd_check("after rejects (2,3)", 1, 2, 3, 1, 1, 0);
        rd_check("after rejects (4,4)", 1, 4, 4, 0, 0, 0);

        repeat (3) connect(1, 2, 5, lat);
        rd_check("old edge age 4", 1, 2, 3, 1, 4, 0);
        scan_all();

        cmd_class = 2'd1; cmd_node1 = 3'd6; cmd_node2 = 3'd7;
        cmd_valid = 1'b1; prune_start = 1'b1;
        #1;
        chk("ready low with prune_start", int'(cmd_ready), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; prune_start = 1'b0;
        model_prune();
        chk("prune start busy", int'(busy), 1);
        chk("prune start no err", int'(cmd_err), 0);
        cyc = 0;
        while (!prune_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("prune length", cyc, 14);
        chk("done busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("prune_done pulse end", int'(prune_done), 0);
        chk("post prune busy", int'(busy), 0);
        chk("post prune ready", int'(cmd_ready), 1);
        rd_check("pruned (2,3)", 1, 2, 3, 0, 4, 0);
        rd_check("node 3 invalid", 1, 3, 2, 0, 4, 1);
        rd_check("kept (2,5)", 1, 2, 5, 1, 0, 0);
        rd_check("node 5 valid", 1, 5, 2, 1, 0, 0);
        rd_check("ignored req (6,7)", 1, 6, 7, 0, 0, 1);
        scan_all();

        connect(1, 6, 7, lat);
        rd_check("reconnect clears invalid", 1, 6, 7, 1, 0, 0);

        connect(2, 1, 2, lat);
        repeat (16) connect(2, 1, 3, lat);
        rd_check("saturated (1,2)", 2, 1, 2, 1, 15, 0);
        rd_check("saturated (2,1)", 2, 2, 1, 1, 15, 0);
        rd_check("fresh (1,3)", 2, 1, 3, 1, 0, 0);
        scan_all();

        rd_class = 2'd2; rd_node1 = 3'd1; rd_node2 = 3'd2;
        cmd_class = 2'd1; cmd_node1 = 3'd4; cmd_node2 = 3'd6; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_connect(1, 4, 6);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid-sweep reset busy", int'(busy), 0);
        chk("mid-sweep reset cmd_err", int'(cmd_err), 0);
        chk("mid-sweep reset prune_done", int'(prune_done), 0);
        chk("mid-sweep reset rd_present", int'(rd_present), 0);
        chk("mid-sweep reset rd_age", int'(rd_age), 0);
        chk("mid-sweep reset rd_invalid", int'(rd_invalid), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset ready", int'(cmd_ready), 1);
        chk("post reset busy", int'(busy), 0);
        rd_check("post reset (4,6)", 1, 4, 6, 0, 0, 0);
        rd_check("post reset (1,2)", 2, 1, 2, 0, 0, 0);
        scan_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gam_edge_table.md
GAM_EDGE_TABLE -- requirements
Module: gam_edge_table

Interface
REQ-001 The block SHALL take parameter CLASS_COUNT, default 4, meaning number of classes; class index 0 is reserved.
REQ-002 The block SHALL take parameter NODE_COUNT, default 16, meaning nodes per class; node index 0 is reserved.
REQ-003 The block SHALL take parameter AGE_W, default 6, meaning edge age width in bits.
REQ-004 The block SHALL take parameter AGE_MAX, default 20, meaning the prune threshold; AGE_MAX SHALL be at most 2^AGE_W-1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Ports SHALL be as follows, one per entry (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- cmd_valid, in, 1, connect request.
- cmd_ready, out, 1, block can accept a connect request.
- cmd_class, in, $clog2(CLASS_COUNT), class of the edge.
- cmd_node1, in, $clog2(NODE_COUNT), winner node.
- cmd_node2, in, $clog2(NODE_COUNT), second node.
- cmd_err, out, 1, one-cycle pulse when a request is rejected.
- prune_start, in, 1, learning-done pulse that starts pruning.
- busy, out, 1, high while not IDLE.
- prune_done, out, 1, one-cycle pulse at the end of pruning.
- rd_class, in, $clog2(CLASS_COUNT), read class.
- rd_node1, in, $clog2(NODE_COUNT), read row.
- rd_node2, in, $clog2(NODE_COUNT), read column.
- rd_present, out, 1, edge presence.
- rd_age, out, AGE_W, edge age.
- rd_invalid, out, 1, invalid flag of node rd_node1.

Function
REQ-007 The block SHALL run an FSM with states IDLE, AGE_SWEEP, PRUNE and DONE; cmd_ready SHALL be 1 only in IDLE with prune_start low.
REQ-008 A request SHALL be accepted on cmd_valid && cmd_ready; the handshake on clk is the only trigger, and no edge-triggered enables are used.
REQ-009 A request SHALL be rejected when class==0, node==0, node1==node2, or any index is out of range: cmd_err pulses the next cycle, storage is unchanged, and the FSM stays in IDLE.
REQ-010 On a valid accept, the block SHALL set present and age=0 on both (n1,n2) and (n2,n1) of cmd_class in the next cycle and enter AGE_SWEEP with index i=1.
REQ-011 In AGE_SWEEP, one i per cycle for i=1..NODE_COUNT-1: if i is not n1 or n2 and (n1,i) is present, the block SHALL increment the age of both (n1,i) and (i,n1), saturating at 2^AGE_W-1. Absent edges SHALL never change age.
REQ-012 After i=NODE_COUNT-1 the block SHALL return to IDLE; accept-to-cmd_ready latency SHALL be NODE_COUNT cycles exactly.
REQ-013 An accept on an existing edge SHALL reset its age to 0 in both directions and leave its presence set.
REQ-014 prune_start SHALL be honoured only in IDLE, where it has priority over a same-cycle cmd_valid (that request is not accepted); while busy it SHALL be ignored.
REQ-015 PRUNE SHALL process one (class,row) per cycle, for class 1..CLASS_COUNT-1 and row 1..NODE_COUNT-1, taking (CLASS_COUNT-1)*(NODE_COUNT-1) cycles.
REQ-016 Per row, the block SHALL clear present on every edge with age>=AGE_MAX, and set the invalid flag if no present edge remains in that row after the clear; otherwise the invalid flag SHALL be cleared.
REQ-017 After PRUNE the FSM SHALL spend one cycle in DONE with prune_done=1, then return to IDLE; a subsequent connect clears the invalid flag of n1 and n2.
REQ-018 Reads SHALL have 1-cycle registered latency, be valid in any state, and return 0 for index 0 or out-of-range indices.
REQ-019 Symmetry SHALL hold at all times: (a,b) and (b,a) have equal present and age.

Reset
REQ-020 Asserting rst_n low at any time, including mid-sweep or mid-prune, SHALL asynchronously force state IDLE, all present=0, age=0, invalid=0, cmd_err=0, prune_done=0, busy=0, rd_*=0, and cmd_ready=1 once rst_n is high.

Structure
REQ-021 GAM_package SHALL hold CLASS_COUNT, NODE_COUNT, AGE_MAX defaults, the edge_T struct {present, age}, and the FSM state enum.
REQ-022 One combinational sub-module, gam_edge_row_prune, SHALL take a row of edge_T and output the cleared row and the row-empty flag.

Verification (CLASS_COUNT=3, NODE_COUNT=8, AGE_W=4, AGE_MAX=3)
REQ-023 Connect (1,2,3) -> (2,3) and (3,2) read present=1, age=0; cmd_ready low for 8 cycles.
REQ-024 Connect (1,2,3), then (1,2,5) -> age(2,3)=age(3,2)=1, age(2,5)=0; (2,4) stays absent with age 0.
REQ-025 Connect (1,2,3), then (1,2,5) four times -> prune_start -> (2,3) cleared, node 3 invalid, nodes 2 and 5 valid; prune_done after 14 cycles plus DONE.
REQ-026 cmd_node1=cmd_node2=4, or class 0 -> cmd_err pulse, no state change; prune_start with cmd_valid in the same cycle -> prune runs and the request is not accepted.
REQ-027 Connect 17 times with n1 fixed -> the age of an older edge saturates at 15 without wrapping.
REQ-028 Assert rst_n low during cycle 4 of AGE_SWEEP -> all reads return 0 and cmd_ready=1 after release.
